// File: rtl/ros2rapper_tx_pkg.sv
// Shared constants for the ROS2 TX timer bank: channel index map and request FSM states.
package ros2rapper_tx_pkg;

    localparam int unsigned CH_INTERVAL    = 0;
    localparam int unsigned CH_SPDP_WR     = 1;
    localparam int unsigned CH_SEDP_PUB_WR = 2;
    localparam int unsigned CH_SEDP_SUB_WR = 3;
    localparam int unsigned CH_SEDP_PUB_HB = 4;
    localparam int unsigned CH_SEDP_SUB_HB = 5;
    localparam int unsigned CH_SEDP_PUB_AN = 6;
    localparam int unsigned CH_SEDP_SUB_AN = 7;
    localparam int unsigned CH_APP_WR      = 8;
    localparam int unsigned TX_NUM_CH      = 9;

    typedef enum logic {
        REQ_IDLE  = 1'b0,
        REQ_OFFER = 1'b1
    } req_state_t;

endpackage

// File: rtl/ros2rapper_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping modulo NUM_CH.
module ros2rapper_rr_arbiter #(
    parameter int unsigned NUM_CH = 9
) (
    input  logic [NUM_CH-1:0]         i_req,
    input  logic [$clog2(NUM_CH)-1:0] i_ptr,
    output logic [$clog2(NUM_CH)-1:0] o_idx,
    output logic                      o_any
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);

    function automatic logic [SEL_W-1:0] first_from(
        input logic [NUM_CH-1:0] req,
        input logic [SEL_W-1:0]  ptr
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        int unsigned      j;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && req[SEL_W'(j)]) begin
                idx   = SEL_W'(j);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_comb begin
        o_any = |i_req;
        o_idx = first_from(i_req, i_ptr);
    end

endmodule

// File: rtl/ros2rapper_tx_timer_bank.sv
// Bank of prescaled down-counting TX timers with a round-robin elapsed-channel request handshake.
// Optional: define ROS2_TX_TIMER_AUTORELOAD_EN to reload a channel's count on its handshake.
module ros2rapper_tx_timer_bank
    import ros2rapper_tx_pkg::*;
#(
    parameter int unsigned NUM_CH         = TX_NUM_CH,
    parameter int unsigned PRESCALER_DIV  = 16,
    parameter int unsigned CNT_W          = 22,
    parameter int unsigned DEFAULT_PERIOD = 3125000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_period_we,
    input  logic [$clog2(NUM_CH)-1:0] i_period_sel,
    input  logic [CNT_W-1:0]          i_period_data,
    input  logic [NUM_CH-1:0]         i_cnt_set,
    input  logic [NUM_CH-1:0]         i_cnt_clr,
    output logic [NUM_CH-1:0]         o_cnt_elapsed,
    output logic                      o_req_valid,
    output logic [$clog2(NUM_CH)-1:0] o_req_ch,
    input  logic                      i_req_ready,
    output logic                      o_tick
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);
    localparam int unsigned PRE_W = $clog2(PRESCALER_DIV);

    logic [PRE_W-1:0] presc_q;
    logic             tick;

    assign tick   = i_enable && (presc_q == PRE_W'(PRESCALER_DIV - 1));
    assign o_tick = tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      presc_q <= '0;
        else if (tick)     presc_q <= '0;
        else if (i_enable) presc_q <= presc_q + 1'b1;
    end

    req_state_t       state_q, state_d;
    logic [SEL_W-1:0] req_ch_q, req_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;
    logic             hs;

    ros2rapper_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req (o_cnt_elapsed),
        .i_ptr (rr_ptr_q),
        .o_idx (arb_idx),
        .o_any (arb_any)
    );

    assign hs          = (state_q == REQ_OFFER) && i_req_ready;
    assign o_req_valid = (state_q == REQ_OFFER);
    assign o_req_ch    = req_ch_q;

    // Ready wins over a same-cycle set of the offered channel, so that case completes the handshake.
    always_comb begin
        state_d  = state_q;
        req_ch_d = req_ch_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            REQ_IDLE: begin
                if (arb_any) begin
                    state_d  = REQ_OFFER;
                    req_ch_d = arb_idx;
                end
            end
            REQ_OFFER: begin
                if (hs) begin
                    state_d  = REQ_IDLE;
                    rr_ptr_d = (req_ch_q == SEL_W'(NUM_CH - 1)) ? '0 : req_ch_q + 1'b1;
                end else if (i_cnt_set[req_ch_q]) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= REQ_IDLE;
            req_ch_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            req_ch_q <= req_ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] cnt_q;

        // A set reads period_q before this edge's write lands, so it loads the old period.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                period_q <= CNT_W'(DEFAULT_PERIOD);
                cnt_q    <= '0;
            end else begin
                if (i_period_we && (i_period_sel == SEL_W'(g)))
                    period_q <= i_period_data;
                if (i_cnt_clr[g])
                    cnt_q <= '0;
                else if (i_cnt_set[g])
                    cnt_q <= period_q;
`ifdef ROS2_TX_TIMER_AUTORELOAD_EN
                else if (hs && (req_ch_q == SEL_W'(g)))
                    cnt_q <= period_q;
`endif
                else if (tick && (cnt_q != '0))
                    cnt_q <= cnt_q - 1'b1;
            end
        end

        assign o_cnt_elapsed[g] = (cnt_q == '0);
    end

endmodule
